// File: rtl/cmd_queue_rowhit.sv
// -----------------------------------------------------------------------------
// cmd_queue_rowhit
//
// Purpose:
//   DDR command queue placed between the host command front end and the main
//   controller FSM. Buffers packed command words in a power-of-two circular
//   FIFO. Each head entry is tagged with its row state (bank closed, row hit
//   or row miss) by comparing it against a per-bank open-row table, so the
//   scheduler can choose ACTIVE / PRECHARGE sequences without decoding the
//   address again. Row hits that are dequeued are counted in a saturating
//   16-bit statistic.
//
// Command word layout, MSB to LSB:
//   r_w | rsv | row[ROW_BITS] | rsv | burst_length | rsv | auto_precharge |
//   col[COL_BITS] | bank[BANK_BITS]
//   Reserved bits are stored and passed through unchanged.
//
// Ports:
//   clk            in   clock; all logic is on the rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   producer has a command
//   in_ready       out  queue can accept (count != DEPTH)
//   in_cmd         in   command word (CMD_W bits)
//   out_valid      out  head entry available (count != 0)
//   out_ready      in   consumer takes the head entry
//   out_cmd        out  head command word, 0 when out_valid = 0
//   out_row_state  out  0 = bank closed, 1 = row hit, 2 = row miss;
//                       0 when out_valid = 0
//   close_valid    in   external precharge of a single bank
//   close_bank     in   bank being precharged
//   close_all      in   precharge-all / refresh, closes every bank
//   count          out  queue occupancy
//   hit_cnt        out  row hits dequeued, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module cmd_queue_rowhit #(
  parameter int DEPTH     = 8,
  parameter int ROW_BITS  = 13,
  parameter int COL_BITS  = 10,
  parameter int BANK_BITS = 3,
  localparam int CMD_W    = ROW_BITS + COL_BITS + BANK_BITS + 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CMD_W-1:0]           in_cmd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CMD_W-1:0]           out_cmd,
  output logic [1:0]                 out_row_state,
  input  logic                       close_valid,
  input  logic [BANK_BITS-1:0]       close_bank,
  input  logic                       close_all,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                hit_cnt
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  // Field positions inside the command word, counted from the LSB.
  localparam int AP_POS  = BANK_BITS + COL_BITS;
  localparam int ROW_LSB = BANK_BITS + COL_BITS + 4;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [1:0] ROW_CLOSED = 2'd0;
  localparam logic [1:0] ROW_HIT    = 2'd1;
  localparam logic [1:0] ROW_MISS   = 2'd2;

  logic [CMD_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_BITS-1:0]  bank_row [NUM_BANKS];

  logic                 push;
  logic                 pop;
  logic [CMD_W-1:0]     head_cmd;
  logic [BANK_BITS-1:0] head_bank;
  logic [ROW_BITS-1:0]  head_row;
  logic                 head_ap;
  logic [1:0]           head_state;

  // Handshake qualification. A full queue refuses pushes even when a pop
  // happens in the same cycle, so in_ready depends on registered state only.
  always_comb begin
    in_ready  = (count != FULL_COUNT);
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Head decode. The head slot may hold stale data when the queue is empty,
  // so the visible outputs are forced to zero unless out_valid is set.
  always_comb begin
    head_cmd  = mem[rd_ptr];
    head_bank = head_cmd[BANK_BITS-1:0];
    head_row  = head_cmd[ROW_LSB +: ROW_BITS];
    head_ap   = head_cmd[AP_POS];
  end

  // Row classification uses the table as it stands this cycle; any update
  // caused by this cycle's pop or close only shows up on the next cycle.
  always_comb begin
    head_state = ROW_CLOSED;
    if (bank_open[head_bank]) begin
      if (bank_row[head_bank] == head_row) begin
        head_state = ROW_HIT;
      end else begin
        head_state = ROW_MISS;
      end
    end
  end

  always_comb begin
    out_cmd       = '0;
    out_row_state = ROW_CLOSED;
    if (out_valid) begin
      out_cmd       = head_cmd;
      out_row_state = head_state;
    end
  end

  // Storage array. Contents are not reset because reset discards the queue
  // by clearing the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally and a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Open-row table. The three sources are applied in order so a later one
  // wins: precharge-all, then a single-bank close, then the popped command.
  // This lets a pop re-open a bank that is being closed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_row[b] <= '0;
      end
    end else begin
      if (close_all) begin
        bank_open <= '0;
      end
      if (close_valid) begin
        bank_open[close_bank] <= 1'b0;
      end
      if (pop) begin
        if (head_ap) begin
          bank_open[head_bank] <= 1'b0;
        end else begin
          bank_open[head_bank] <= 1'b1;
          bank_row[head_bank]  <= head_row;
        end
      end
    end
  end

  // Saturating statistic of row hits actually handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (pop && (head_state == ROW_HIT) && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule
